// File: rtl/seq_divider_if.sv
// Handshake and operand/result bundle between the control FSM and seq_divider.
// Optional build macro: DIV_SIGNED_EN adds the is_signed request signal.
interface seq_divider_if #(
   parameter int unsigned WIDTH = 32
);
   logic             start;
   logic [WIDTH-1:0] dividend;
   logic [WIDTH-1:0] divisor;
`ifdef DIV_SIGNED_EN
   logic             is_signed;
`endif
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] quotient;
   logic [WIDTH-1:0] remainder;
   logic             div_by_zero;

`ifdef DIV_SIGNED_EN
   modport master (
      output start, dividend, divisor, is_signed,
      input  busy, done, quotient, remainder, div_by_zero
   );
   modport slave (
      input  start, dividend, divisor, is_signed,
      output busy, done, quotient, remainder, div_by_zero
   );
`else
   modport master (
      output start, dividend, divisor,
      input  busy, done, quotient, remainder, div_by_zero
   );
   modport slave (
      input  start, dividend, divisor,
      output busy, done, quotient, remainder, div_by_zero
   );
`endif
endinterface

// File: rtl/seq_divider.sv
// Iterative restoring divider: one trial subtraction per cycle, WIDTH+1 cycle latency.
// Optional build macro: DIV_SIGNED_EN enables two's-complement operation via is_signed.
module seq_divider #(
   parameter int unsigned WIDTH = 32
) (
   input logic          clk,
   input logic          reset,
   seq_divider_if.slave bus
);

   localparam int unsigned CW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

   state_e           state_q;
   logic [CW-1:0]    cnt_q;
   logic [WIDTH-1:0] rem_q;
   logic [WIDTH-1:0] quo_q;
   logic [WIDTH-1:0] den_q;

   logic [WIDTH:0]   r_sh;
   logic [WIDTH:0]   trial;
   logic [WIDTH-1:0] q_sh;
   logic [WIDTH-1:0] r_nxt;
   logic [WIDTH-1:0] q_nxt;
   logic [WIDTH-1:0] q_fin;
   logic [WIDTH-1:0] r_fin;
   logic [WIDTH-1:0] dvd_mag;
   logic [WIDTH-1:0] dsr_mag;

`ifdef DIV_SIGNED_EN
   logic neg_q_q;
   logic neg_r_q;
   logic a_neg;
   logic b_neg;
`endif

   // One restoring step: shift {R,Q}, trial-subtract, keep difference when non-negative.
   always_comb begin
      r_sh  = {rem_q, quo_q[WIDTH-1]};
      q_sh  = {quo_q[WIDTH-2:0], 1'b0};
      trial = r_sh - {1'b0, den_q};
      if (trial[WIDTH]) begin
         r_nxt = r_sh[WIDTH-1:0];
         q_nxt = q_sh;
      end else begin
         r_nxt = trial[WIDTH-1:0];
         q_nxt = {q_sh[WIDTH-1:1], 1'b1};
      end
   end

`ifdef DIV_SIGNED_EN
   // Operand magnitudes at accept and sign fix-up of the final step's result.
   always_comb begin
      a_neg   = bus.is_signed & bus.dividend[WIDTH-1];
      b_neg   = bus.is_signed & bus.divisor[WIDTH-1];
      dvd_mag = a_neg ? -bus.dividend : bus.dividend;
      dsr_mag = b_neg ? -bus.divisor : bus.divisor;
      // -2^(W-1) / -1 falls out naturally: the magnitude quotient negates to itself.
      q_fin   = neg_q_q ? -q_nxt : q_nxt;
      r_fin   = neg_r_q ? -r_nxt : r_nxt;
   end
`else
   // Unsigned only: operands and results pass straight through.
   always_comb begin
      dvd_mag = bus.dividend;
      dsr_mag = bus.divisor;
      q_fin   = q_nxt;
      r_fin   = r_nxt;
   end
`endif

   // Control FSM with datapath registers and registered outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q         <= StIdle;
         cnt_q           <= '0;
         rem_q           <= '0;
         quo_q           <= '0;
         den_q           <= '0;
         bus.busy        <= 1'b0;
         bus.done        <= 1'b0;
         bus.quotient    <= '0;
         bus.remainder   <= '0;
         bus.div_by_zero <= 1'b0;
`ifdef DIV_SIGNED_EN
         neg_q_q         <= 1'b0;
         neg_r_q         <= 1'b0;
`endif
      end else begin
         bus.done <= 1'b0;
         unique case (state_q)
            StIdle, StDone: begin
               if (bus.start) begin
                  bus.div_by_zero <= 1'b0;
                  if (bus.divisor == '0) begin
                     // Divide by zero completes immediately without entering RUN.
                     state_q         <= StDone;
                     bus.done        <= 1'b1;
                     bus.quotient    <= '1;
                     bus.remainder   <= bus.dividend;
                     bus.div_by_zero <= 1'b1;
                  end else begin
                     state_q  <= StRun;
                     bus.busy <= 1'b1;
                     cnt_q    <= CW'(WIDTH);
                     rem_q    <= '0;
                     quo_q    <= dvd_mag;
                     den_q    <= dsr_mag;
`ifdef DIV_SIGNED_EN
                     neg_q_q  <= a_neg ^ b_neg;
                     neg_r_q  <= a_neg;
`endif
                  end
               end else begin
                  state_q <= StIdle;
               end
            end
            StRun: begin
               rem_q <= r_nxt;
               quo_q <= q_nxt;
               cnt_q <= cnt_q - CW'(1);
               if (cnt_q == CW'(1)) begin
                  state_q       <= StDone;
                  bus.busy      <= 1'b0;
                  bus.done      <= 1'b1;
                  bus.quotient  <= q_fin;
                  bus.remainder <= r_fin;
               end
            end
            default: begin
               state_q  <= StIdle;
               bus.busy <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_seq_divider.sv
// Directed self-checking bench for seq_divider (WIDTH = 32).
// Signed vectors run only when DIV_SIGNED_EN is defined.
module tb_seq_divider;

   localparam int unsigned WIDTH = 32;

   logic clk;
   logic reset;
   int   n_tests;
   int   n_fail;
   int   lat;
   int   bcnt;
   int   pulses;

   seq_divider_if #(.WIDTH(WIDTH)) bus_if ();

   seq_divider #(.WIDTH(WIDTH)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   // Called at a negedge: present a request to the next rising edge.
   task automatic launch(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
      bus_if.start    = 1'b1;
      bus_if.dividend = a;
      bus_if.divisor  = b;
   endtask

   // Counts negedges after launch until done; pulse_at > 0 injects a stray start mid-run.
   task automatic wait_done(input int pulse_at, output int l, output int bc);
      l  = 0;
      bc = 0;
      for (int n = 1; n <= 60; n++) begin
         @(negedge clk);
         bus_if.start = 1'b0;
         if (n == pulse_at) launch(32'd7, 32'd7);
         if (bus_if.busy) bc++;
         if (bus_if.done) begin
            l = n;
            break;
         end
      end
   endtask

   initial begin
      n_tests = 0;
      n_fail  = 0;
      reset   = 1'b1;
      bus_if.start    = 1'b0;
      bus_if.dividend = '0;
      bus_if.divisor  = '0;
`ifdef DIV_SIGNED_EN
      bus_if.is_signed = 1'b0;
`endif
      repeat (3) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      check("rst_busy", bus_if.busy, 0);
      check("rst_done", bus_if.done, 0);
      check("rst_quot", bus_if.quotient, 0);
      check("rst_rem", bus_if.remainder, 0);
      check("rst_dbz", bus_if.div_by_zero, 0);

      // 100 / 7
      launch(32'd100, 32'd7);
      wait_done(0, lat, bcnt);
      check("u100_7_lat", lat, 33);
      check("u100_7_busy", bcnt, 32);
      check("u100_7_q", bus_if.quotient, 14);
      check("u100_7_r", bus_if.remainder, 2);
      check("u100_7_dbz", bus_if.div_by_zero, 0);
      @(negedge clk);
      check("done_one_cycle", bus_if.done, 0);
      check("hold_q_idle", bus_if.quotient, 14);

      // all-ones / 1, then dividend smaller than divisor
      launch(32'hFFFF_FFFF, 32'd1);
      wait_done(0, lat, bcnt);
      check("max_1_q", bus_if.quotient, 32'hFFFF_FFFF);
      check("max_1_r", bus_if.remainder, 0);
      @(negedge clk);
      launch(32'd5, 32'd9);
      wait_done(0, lat, bcnt);
      check("u5_9_q", bus_if.quotient, 0);
      check("u5_9_r", bus_if.remainder, 5);

      // divide by zero
      @(negedge clk);
      launch(32'd42, 32'd0);
      wait_done(0, lat, bcnt);
      check("dz_lat", lat, 1);
      check("dz_busy", bcnt, 0);
      check("dz_q", bus_if.quotient, 32'hFFFF_FFFF);
      check("dz_r", bus_if.remainder, 42);
      check("dz_flag", bus_if.div_by_zero, 1);

      // stray start mid-run is ignored
      @(negedge clk);
      launch(32'd1000, 32'd10);
      wait_done(5, lat, bcnt);
      check("ign_lat", lat, 33);
      check("ign_q", bus_if.quotient, 100);
      check("ign_r", bus_if.remainder, 0);
      check("ign_dbz", bus_if.div_by_zero, 0);

      // back-to-back: start during done cycle
      launch(32'd50, 32'd6);
      wait_done(0, lat, bcnt);
      check("b2b_lat", lat, 33);
      check("b2b_busy", bcnt, 32);
      check("b2b_q", bus_if.quotient, 8);
      check("b2b_r", bus_if.remainder, 2);

      // reset at RUN cycle 10
      @(negedge clk);
      launch(32'd1000, 32'd3);
      @(negedge clk);
      bus_if.start = 1'b0;
      repeat (9) @(negedge clk);
      check("run10_busy", bus_if.busy, 1);
      check("run10_hold_q", bus_if.quotient, 8);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      check("abort_busy", bus_if.busy, 0);
      check("abort_done", bus_if.done, 0);
      check("abort_q", bus_if.quotient, 0);
      check("abort_r", bus_if.remainder, 0);
      pulses = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (bus_if.done || bus_if.busy) pulses++;
      end
      check("abort_no_done", pulses, 0);
      launch(32'd9, 32'd3);
      wait_done(0, lat, bcnt);
      check("u9_3_lat", lat, 33);
      check("u9_3_q", bus_if.quotient, 3);
      check("u9_3_r", bus_if.remainder, 0);

`ifdef DIV_SIGNED_EN
      @(negedge clk);
      bus_if.is_signed = 1'b1;
      launch(32'hFFFF_FFF9, 32'd2);
      wait_done(0, lat, bcnt);
      check("s_m7_2_lat", lat, 33);
      check("s_m7_2_q", bus_if.quotient, 32'hFFFF_FFFD);
      check("s_m7_2_r", bus_if.remainder, 32'hFFFF_FFFF);
      @(negedge clk);
      launch(32'd7, 32'hFFFF_FFFE);
      wait_done(0, lat, bcnt);
      check("s_7_m2_q", bus_if.quotient, 32'hFFFF_FFFD);
      check("s_7_m2_r", bus_if.remainder, 1);
      @(negedge clk);
      launch(32'h8000_0000, 32'hFFFF_FFFF);
      wait_done(0, lat, bcnt);
      check("s_ovf_q", bus_if.quotient, 32'h8000_0000);
      check("s_ovf_r", bus_if.remainder, 0);
      check("s_ovf_dbz", bus_if.div_by_zero, 0);
      @(negedge clk);
      bus_if.is_signed = 1'b0;
      launch(32'hFFFF_FFF9, 32'd2);
      wait_done(0, lat, bcnt);
      check("s_off_q", bus_if.quotient, 32'h7FFF_FFFC);
      check("s_off_r", bus_if.remainder, 1);
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
